// File: rtl/voice_alloc.sv
// -----------------------------------------------------------------------------
// voice_alloc
//
// Polyphonic key-to-voice scheduler. It parses a PS/2 Set-2 scancode stream
// (make codes, F0 break prefix, E0 extended prefix) and maps the number-row
// keys 1..7 to note codes 1..7. It then shares a pool of VOICES voices among
// the keys that are held. When every voice is busy, a new key steals the
// least recently allocated voice.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   code_valid  one-cycle strobe qualifying code
//   code        scancode byte
//   voice_note  3-bit note per voice, voice i at [3i+2:3i]; 0 = silent
//   voice_on    per-voice "key held" flag
//   voice_trig  per-voice one-cycle pulse on a new note assignment
//   steal       one-cycle pulse when an allocation evicted a held voice
//
// All outputs are registered, so the response to a byte appears one cycle
// after its strobe.
// -----------------------------------------------------------------------------
module voice_alloc #(
    parameter int VOICES = 4,
    parameter int AGE_W  = $clog2(VOICES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  code_valid,
    input  logic [7:0]            code,
    output logic [3*VOICES-1:0]   voice_note,
    output logic [VOICES-1:0]     voice_on,
    output logic [VOICES-1:0]     voice_trig,
    output logic                  steal
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           note_q [VOICES];
    logic [2:0]           note_d [VOICES];
    logic [AGE_W-1:0]     age_q  [VOICES];
    logic [AGE_W-1:0]     age_d  [VOICES];
    logic [VOICES-1:0]    on_q, on_d;
    logic [VOICES-1:0]    trig_q, trig_d;
    logic                 steal_q, steal_d;

    // Scancode to note lookup; 0 means the key is not part of the note row.
    logic [2:0] key_note;
    always_comb begin
        case (code)
            8'h16:   key_note = 3'd1;
            8'h1E:   key_note = 3'd2;
            8'h26:   key_note = 3'd3;
            8'h25:   key_note = 3'd4;
            8'h2E:   key_note = 3'd5;
            8'h36:   key_note = 3'd6;
            8'h3D:   key_note = 3'd7;
            default: key_note = 3'd0;
        endcase
    end

    // Voice search: the voice already holding this note (repeat or break),
    // the lowest-index free voice, and the oldest voice (age VOICES-1).
    logic              hit;
    logic [AGE_W-1:0]  hit_idx;
    logic              any_free;
    logic [AGE_W-1:0]  free_idx;
    logic [AGE_W-1:0]  old_idx;
    logic [AGE_W-1:0]  alloc_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (on_q[i] && (note_q[i] == key_note)) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
            if (age_q[i] == AGE_W'(VOICES - 1)) begin
                old_idx = AGE_W'(i);
            end
        end
        // Scan downward so the lowest free index is the last one written.
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!on_q[i]) begin
                any_free = 1'b1;
                free_idx = AGE_W'(i);
            end
        end
        alloc_idx = any_free ? free_idx : old_idx;
    end

    // Parser and voice-pool next state.
    logic make_ev;
    logic brk_ev;

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        age_d   = age_q;
        on_d    = on_q;
        trig_d  = '0;
        steal_d = 1'b0;
        make_ev = 1'b0;
        brk_ev  = 1'b0;

        if (code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (code == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (code == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (key_note != 3'd0) begin
                        make_ev = 1'b1;
                    end
                end
                S_BRK: begin
                    // A stray F0/E0 here maps to no note, so it is simply
                    // consumed and the parser returns to IDLE.
                    state_d = S_IDLE;
                    if (key_note != 3'd0) begin
                        brk_ev = 1'b1;
                    end
                end
                S_EXT: begin
                    state_d = (code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A make for a note that is already sounding is a typematic repeat
        // and leaves everything untouched.
        if (make_ev && !hit) begin
            note_d[alloc_idx] = key_note;
            on_d[alloc_idx]   = 1'b1;
            trig_d[alloc_idx] = 1'b1;
            steal_d           = !any_free;
            // Move the allocated voice to the front of the age order; every
            // voice that was younger than it shifts back by one. This keeps
            // the ages a permutation of 0..VOICES-1.
            for (int j = 0; j < VOICES; j++) begin
                if (age_q[j] < age_q[alloc_idx]) begin
                    age_d[j] = age_q[j] + AGE_W'(1);
                end
            end
            age_d[alloc_idx] = '0;
        end

        // A break for a note nobody holds (stolen or never made) is dropped.
        if (brk_ev && hit) begin
            note_d[hit_idx] = 3'd0;
            on_d[hit_idx]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            on_q    <= '0;
            trig_q  <= '0;
            steal_q <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= 3'd0;
                age_q[i]  <= AGE_W'(i);
            end
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            trig_q  <= trig_d;
            steal_q <= steal_d;
            note_q  <= note_d;
            age_q   <= age_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_note_out
            assign voice_note[3*gi +: 3] = note_q[gi];
        end
    endgenerate

    assign voice_on   = on_q;
    assign voice_trig = trig_q;
    assign steal      = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// -----------------------------------------------------------------------------
// tb_voice_alloc
//
// Directed scoreboard bench for voice_alloc (VOICES=4). The stimulus process
// pushes the hand-computed expected outputs for each byte it sends; a monitor
// pops and compares one cycle after each accepted strobe, checks the reset
// state after every reset cycle, and checks that the pulses stay low on
// cycles without a byte.
// -----------------------------------------------------------------------------
module tb_voice_alloc;

    localparam int VOICES = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                code_valid;
    logic [7:0]          code;
    logic [3*VOICES-1:0] voice_note;
    logic [VOICES-1:0]   voice_on;
    logic [VOICES-1:0]   voice_trig;
    logic                steal;

    voice_alloc #(.VOICES(VOICES)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .voice_note (voice_note),
        .voice_on   (voice_on),
        .voice_trig (voice_trig),
        .steal      (steal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  code;
        logic [11:0] note;
        logic [3:0]  on;
        logic [3:0]  trig;
        logic        st;
    } exp_t;

    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    logic sent_flag = 1'b0;
    logic rst_flag  = 1'b0;
    logic done      = 1'b0;

    always @(posedge clk) begin
        sent_flag <= code_valid && !rst;
        rst_flag  <= rst;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_flag) begin
            checks++;
            if (voice_note !== 12'h000 || voice_on !== 4'b0000 ||
                voice_trig !== 4'b0000 || steal !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got note=%h on=%b trig=%b steal=%b, want all zero",
                         voice_note, voice_on, voice_trig, steal);
            end
        end else if (sent_flag) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output present but no expectation queued");
            end else begin
                e = exp_q.pop_front();
                $display("code %h: note=%h on=%b trig=%b steal=%b (want note=%h on=%b trig=%b steal=%b)",
                         e.code, voice_note, voice_on, voice_trig, steal,
                         e.note, e.on, e.trig, e.st);
                if (voice_note !== e.note || voice_on !== e.on ||
                    voice_trig !== e.trig || steal !== e.st) begin
                    errors++;
                    $display("FAIL byte_%h: got note=%h on=%b trig=%b steal=%b, want note=%h on=%b trig=%b steal=%b",
                             e.code, voice_note, voice_on, voice_trig, steal,
                             e.note, e.on, e.trig, e.st);
                end
            end
        end else begin
            checks++;
            if (voice_trig !== 4'b0000 || steal !== 1'b0) begin
                errors++;
                $display("FAIL idle_pulse: got trig=%b steal=%b, want trig=0000 steal=0",
                         voice_trig, steal);
            end
        end

        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Pack four per-voice notes, voice 3 first.
    function automatic logic [11:0] nv(input logic [2:0] a3, input logic [2:0] a2,
                                       input logic [2:0] a1, input logic [2:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // Drive one byte for one cycle and queue its expected response.
    // Consecutive calls produce back-to-back strobes.
    task automatic send(input logic [7:0] c, input logic [11:0] en,
                        input logic [3:0] eon, input logic [3:0] etr,
                        input logic est);
        exp_t e;
        e.code = c;
        e.note = en;
        e.on   = eon;
        e.trig = etr;
        e.st   = est;
        exp_q.push_back(e);
        code       = c;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single note on and off.
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0001, 1'b0);
        @(negedge clk);
        send(8'hF0, nv(0,0,0,1), 4'b0001, 4'b0000, 1'b0);
        send(8'h16, nv(0,0,0,0), 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);

        // Fill all four voices back to back, then steal the oldest.
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0001, 1'b0);
        send(8'h1E, nv(0,0,2,1), 4'b0011, 4'b0010, 1'b0);
        send(8'h26, nv(0,3,2,1), 4'b0111, 4'b0100, 1'b0);
        send(8'h25, nv(4,3,2,1), 4'b1111, 4'b1000, 1'b0);
        send(8'h2E, nv(4,3,2,5), 4'b1111, 4'b0001, 1'b1);
        // Break of the stolen note does nothing.
        send(8'hF0, nv(4,3,2,5), 4'b1111, 4'b0000, 1'b0);
        send(8'h16, nv(4,3,2,5), 4'b1111, 4'b0000, 1'b0);
        @(negedge clk);

        // Typematic repeat.
        do_reset();
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0001, 1'b0);
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0000, 1'b0);
        send(8'h1E, nv(0,0,2,1), 4'b0011, 4'b0010, 1'b0);
        @(negedge clk);

        // Free voice reuse, then steal of oldest.
        do_reset();
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0001, 1'b0);
        send(8'h1E, nv(0,0,2,1), 4'b0011, 4'b0010, 1'b0);
        send(8'h26, nv(0,3,2,1), 4'b0111, 4'b0100, 1'b0);
        send(8'h25, nv(4,3,2,1), 4'b1111, 4'b1000, 1'b0);
        send(8'hF0, nv(4,3,2,1), 4'b1111, 4'b0000, 1'b0);
        send(8'h1E, nv(4,3,0,1), 4'b1101, 4'b0000, 1'b0);
        send(8'h36, nv(4,3,6,1), 4'b1111, 4'b0010, 1'b0);
        send(8'h3D, nv(4,3,6,7), 4'b1111, 4'b0001, 1'b1);
        @(negedge clk);

        // Extended keys are ignored (16 would otherwise steal, 36 would release).
        send(8'hE0, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'h16, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'hE0, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'hF0, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'h36, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        // F0,F0 returns to IDLE, so 16 is a make and steals voice 2 (oldest).
        send(8'hF0, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'hF0, nv(4,3,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'h16, nv(4,1,6,7), 4'b1111, 4'b0100, 1'b1);
        // Unmapped codes are ignored in both make and break form.
        send(8'h1C, nv(4,1,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'hF0, nv(4,1,6,7), 4'b1111, 4'b0000, 1'b0);
        send(8'h1C, nv(4,1,6,7), 4'b1111, 4'b0000, 1'b0);
        @(negedge clk);

        // Pending F0 discarded by reset; a strobe during reset is ignored.
        send(8'hF0, nv(4,1,6,7), 4'b1111, 4'b0000, 1'b0);
        rst        = 1'b1;
        code       = 8'h16;
        code_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        code_valid = 1'b0;
        @(negedge clk);
        send(8'h16, nv(0,0,0,1), 4'b0001, 4'b0001, 1'b0);
        repeat (2) @(negedge clk);

        done = 1'b1;
    end

endmodule
